// File: rtl/conv_mem_if.sv
// Memory-port bundle between the conv engine (or a bench) and conv_mem_responder.
// Carries the engine-side request/response signals, the bench preload/peek port
// and the responder's status outputs.
interface conv_mem_if #(
    parameter int AW = 10
);
    // Engine-side memory protocol
    logic        R_req;
    logic [31:0] addr;
    logic [3:0]  W_req;
    logic [31:0] W_data;
    logic [31:0] R_data;
    logic        R_valid;

    // Bench preload / peek port
    logic          ld_en;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic [31:0]   ld_rdata;

    // Status
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic        err;

    modport master (
        output R_req, addr, W_req, W_data,
        output ld_en, ld_we, ld_addr, ld_wdata,
        input  R_data, R_valid, ld_rdata, rd_cnt, wr_cnt, err
    );

    modport slave (
        input  R_req, addr, W_req, W_data,
        input  ld_en, ld_we, ld_addr, ld_wdata,
        output R_data, R_valid, ld_rdata, rd_cnt, wr_cnt, err
    );
endinterface

// File: rtl/conv_mem_responder.sv
// Word-addressed SRAM responder for the conv engine memory port.
// Adds a programmable read latency (RD_LAT, 1..4), byte-lane writes, a bench
// preload/peek port, saturating access counters and a sticky error flag.
module conv_mem_responder #(
    parameter int DEPTH  = 1024,
    parameter int AW     = 10,
    parameter int RD_LAT = 1
) (
    input logic       clk,
    input logic       rst,
    conv_mem_if.slave bus
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic          hi_bits_set;
    logic          out_of_range;
    logic          misaligned;
    logic          rd_acc;
    logic          wr_acc;
    logic          ld_wr;
    logic          ld_clash;
    logic          bus_wr_en;
    logic          access_err;
    logic [31:0]   rd_word;

    // Read pipeline: stage 0 captures at the request edge, stage RD_LAT-1 feeds R_data.
    logic [RD_LAT-1:0] pipe_v;
    logic [31:0]       pipe_d [RD_LAT];

    assign word_idx     = bus.addr[AW+1:2];
    assign hi_bits_set  = |bus.addr[31:AW+2];
    assign out_of_range = hi_bits_set || ({1'b0, word_idx} >= DEPTH_W);
    assign misaligned   = |bus.addr[1:0];

    // Bus accesses are only accepted outside reset; the preload port is always live.
    assign rd_acc = rst && bus.R_req;
    assign wr_acc = rst && (|bus.W_req);
    assign ld_wr  = bus.ld_en && bus.ld_we;

    // A preload to the same word as a bus write takes priority over the bus.
    assign ld_clash   = ld_wr && wr_acc && !out_of_range && (bus.ld_addr == word_idx);
    assign bus_wr_en  = wr_acc && !out_of_range && !ld_clash;
    assign access_err = (rd_acc || wr_acc) && (misaligned || out_of_range);

    // Out-of-range reads return zero rather than aliasing onto a real word.
    assign rd_word = out_of_range ? 32'h0 : mem[word_idx];

    assign bus.ld_rdata = mem[bus.ld_addr];

    // Array update: byte-lane bus writes and full-word preloads.
    // NOTE: the array has no reset on purpose -- preloaded contents must survive rst,
    // and clearing a RAM is not something real SRAM macros can do in one cycle.
    always_ff @(posedge clk) begin
        if (bus_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.W_req[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.W_data[8*i +: 8];
                end
            end
        end
        if (ld_wr) begin
            mem[bus.ld_addr] <= bus.ld_wdata;
        end
    end

    // Read-data pipeline payload; qualified by pipe_v, so it needs no reset.
    // NOTE: non-blocking assignments make the capture below see the array as it was
    // before this edge's write, which is exactly the read-first collision behaviour.
    always_ff @(posedge clk) begin
        pipe_d[0] <= rd_word;
        for (int s = 1; s < RD_LAT; s++) begin
            pipe_d[s] <= pipe_d[s-1];
        end
    end

    // Read-valid pipeline and registered response; reset flushes in-flight reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_v      <= '0;
            bus.R_valid <= 1'b0;
            bus.R_data  <= 32'h0;
        end else begin
            pipe_v[0] <= rd_acc;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_v[s] <= pipe_v[s-1];
            end
            bus.R_valid <= pipe_v[RD_LAT-1];
            if (pipe_v[RD_LAT-1]) begin
                bus.R_data <= pipe_d[RD_LAT-1];
            end
        end
    end

    // Saturating access counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.rd_cnt <= 16'h0;
            bus.wr_cnt <= 16'h0;
            bus.err    <= 1'b0;
        end else begin
            if (rd_acc && (bus.rd_cnt != 16'hFFFF)) begin
                bus.rd_cnt <= bus.rd_cnt + 16'd1;
            end
            if (wr_acc && (bus.wr_cnt != 16'hFFFF)) begin
                bus.wr_cnt <= bus.wr_cnt + 16'd1;
            end
            if (access_err || ld_clash) begin
                bus.err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed bench for conv_mem_responder. Two instances (RD_LAT=1 and RD_LAT=3)
// receive identical stimulus so both latencies are checked from one sequence.
// Inputs change and outputs are sampled on the falling edge.
module tb_conv_mem_responder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_mem_if #(.AW(AW)) b1 ();
    conv_mem_if #(.AW(AW)) b3 ();

    // The RD_LAT=3 instance mirrors every input of the RD_LAT=1 instance.
    assign b3.R_req    = b1.R_req;
    assign b3.addr     = b1.addr;
    assign b3.W_req    = b1.W_req;
    assign b3.W_data   = b1.W_data;
    assign b3.ld_en    = b1.ld_en;
    assign b3.ld_we    = b1.ld_we;
    assign b3.ld_addr  = b1.ld_addr;
    assign b3.ld_wdata = b1.ld_wdata;

    conv_mem_responder #(.DEPTH(DEPTH), .AW(AW), .RD_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    conv_mem_responder #(.DEPTH(DEPTH), .AW(AW), .RD_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input logic [AW-1:0] idx, input logic [31:0] data);
        b1.ld_en    = 1'b1;
        b1.ld_we    = 1'b1;
        b1.ld_addr  = idx;
        b1.ld_wdata = data;
        @(negedge clk);
        b1.ld_en    = 1'b0;
        b1.ld_we    = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [AW-1:0] idx, input logic [31:0] exp);
        b1.ld_addr = idx;
        #1;
        check({tag, "_m1"}, b1.ld_rdata, exp);
        check({tag, "_m3"}, b3.ld_rdata, exp);
    endtask

    task automatic check_status(input string tag, input logic [15:0] rd, input logic [15:0] wr,
                                input logic e);
        check({tag, "_rdcnt1"}, 32'(b1.rd_cnt), 32'(rd));
        check({tag, "_wrcnt1"}, 32'(b1.wr_cnt), 32'(wr));
        check({tag, "_err1"},   32'(b1.err),    32'(e));
        check({tag, "_rdcnt3"}, 32'(b3.rd_cnt), 32'(rd));
        check({tag, "_wrcnt3"}, 32'(b3.wr_cnt), 32'(wr));
        check({tag, "_err3"},   32'(b3.err),    32'(e));
    endtask

    task automatic clear_bus();
        b1.R_req  = 1'b0;
        b1.W_req  = 4'h0;
        b1.addr   = 32'h0;
        b1.W_data = 32'h0;
        b1.ld_en  = 1'b0;
        b1.ld_we  = 1'b0;
    endtask

    initial begin
        logic exp_v;

        clear_bus();
        b1.ld_addr  = '0;
        b1.ld_wdata = 32'h0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("rst_rdata1", b1.R_data, 32'h0);
        check("rst_rvalid1", 32'(b1.R_valid), 32'h0);
        check("rst_rvalid3", 32'(b3.R_valid), 32'h0);
        check_status("rst", 16'd0, 16'd0, 1'b0);

        // ---------------- single read, both latencies ----------------
        preload(10'd783, 32'h0001_8000);
        b1.R_req = 1'b1;
        b1.addr  = 32'(783 << 2);
        @(negedge clk);
        clear_bus();
        check("rd1_early_v1", 32'(b1.R_valid), 32'h0);
        @(negedge clk);
        check("rd1_v1", 32'(b1.R_valid), 32'h1);
        check("rd1_d1", b1.R_data, 32'h0001_8000);
        check("rd1_cnt1", 32'(b1.rd_cnt), 32'd1);
        @(negedge clk);
        check("rd1_pulse_v1", 32'(b1.R_valid), 32'h0);
        check("rd1_hold_d1", b1.R_data, 32'h0001_8000);
        check("rd1_early_v3", 32'(b3.R_valid), 32'h0);
        @(negedge clk);
        check("rd1_v3", 32'(b3.R_valid), 32'h1);
        check("rd1_d3", b3.R_data, 32'h0001_8000);
        @(negedge clk);
        check("rd1_pulse_v3", 32'(b3.R_valid), 32'h0);

        // ---------------- back-to-back burst ----------------
        for (int w = 0; w < 4; w++) preload(AW'(w), 32'(10 + w));
        for (int k = 0; k <= 8; k++) begin
            if (k >= 1) begin
                exp_v = (k >= 2) && (k <= 5);
                check("burst_v1", 32'(b1.R_valid), 32'(exp_v));
                if (exp_v) check("burst_d1", b1.R_data, 32'(10 + k - 2));
                exp_v = (k >= 4) && (k <= 7);
                check("burst_v3", 32'(b3.R_valid), 32'(exp_v));
                if (exp_v) check("burst_d3", b3.R_data, 32'(10 + k - 4));
            end
            if (k < 4) begin
                b1.R_req = 1'b1;
                b1.addr  = 32'(k * 4);
            end else begin
                clear_bus();
            end
            @(negedge clk);
        end
        check_status("burst", 16'd5, 16'd0, 1'b0);

        // ---------------- byte-lane write ----------------
        preload(10'd5, 32'hAABB_CCDD);
        b1.W_req  = 4'b0101;
        b1.W_data = 32'h1122_3344;
        b1.addr   = 32'd20;
        @(negedge clk);
        clear_bus();
        check_word("lane_wr", 10'd5, 32'hAA22_CC44);
        check_status("lane_wr", 16'd5, 16'd1, 1'b0);

        // ---------------- preload in parallel with a bus write to another word ----------------
        b1.W_req    = 4'hF;
        b1.W_data   = 32'h3333_3333;
        b1.addr     = 32'd12;
        b1.ld_en    = 1'b1;
        b1.ld_we    = 1'b1;
        b1.ld_addr  = 10'd2;
        b1.ld_wdata = 32'h2222_2222;
        @(negedge clk);
        clear_bus();
        check_word("par_bus", 10'd3, 32'h3333_3333);
        check_word("par_ld", 10'd2, 32'h2222_2222);
        check_status("par", 16'd5, 16'd2, 1'b0);

        // ---------------- read/write collision is read-first ----------------
        preload(10'd5, 32'h0000_0005);
        b1.R_req  = 1'b1;
        b1.W_req  = 4'hF;
        b1.W_data = 32'h0;
        b1.addr   = 32'd20;
        @(negedge clk);
        clear_bus();
        @(negedge clk);
        check("coll_v1", 32'(b1.R_valid), 32'h1);
        check("coll_d1", b1.R_data, 32'h0000_0005);
        b1.R_req = 1'b1;
        b1.addr  = 32'd20;
        @(negedge clk);
        clear_bus();
        @(negedge clk);
        check("coll_d3", b3.R_data, 32'h0000_0005);
        check("coll_next_v1", 32'(b1.R_valid), 32'h1);
        check("coll_next_d1", b1.R_data, 32'h0);
        check_word("coll", 10'd5, 32'h0);
        check_status("coll", 16'd7, 16'd3, 1'b0);

        // ---------------- address errors ----------------
        b1.R_req = 1'b1;
        b1.addr  = 32'h0000_1002;
        @(negedge clk);
        clear_bus();
        check("bad_rd_err1", 32'(b1.err), 32'h1);
        check("bad_rd_err3", 32'(b3.err), 32'h1);
        @(negedge clk);
        check("bad_rd_v1", 32'(b1.R_valid), 32'h1);
        check("bad_rd_d1", b1.R_data, 32'h0);
        b1.W_req  = 4'hF;
        b1.W_data = 32'hFFFF_FFFF;
        b1.addr   = 32'(DEPTH << 2);
        @(negedge clk);
        clear_bus();
        check_word("oor_wr", 10'd0, 32'd10);
        check_status("oor_wr", 16'd8, 16'd4, 1'b1);
        b1.R_req = 1'b1;
        b1.addr  = 32'h0000_0003;
        @(negedge clk);
        clear_bus();
        @(negedge clk);
        check("misal_v1", 32'(b1.R_valid), 32'h1);
        check("misal_d1", b1.R_data, 32'd10);
        check_status("misal", 16'd9, 16'd4, 1'b1);

        // ---------------- reset with a read in flight ----------------
        b1.R_req = 1'b1;
        b1.addr  = 32'(783 << 2);
        @(negedge clk);
        clear_bus();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_d1", b1.R_data, 32'h0);
        check("mid_rst_d3", b3.R_data, 32'h0);
        check_status("mid_rst", 16'd0, 16'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("mid_rst_v1", 32'(b1.R_valid), 32'h0);
            check("mid_rst_v3", 32'(b3.R_valid), 32'h0);
            @(negedge clk);
        end
        check_word("mid_rst_keep", 10'd783, 32'h0001_8000);

        // ---------------- preload beats a bus write to the same word ----------------
        b1.W_req    = 4'hF;
        b1.W_data   = 32'hDEAD_DEAD;
        b1.addr     = 32'd4;
        b1.ld_en    = 1'b1;
        b1.ld_we    = 1'b1;
        b1.ld_addr  = 10'd1;
        b1.ld_wdata = 32'hBEEF_BEEF;
        @(negedge clk);
        clear_bus();
        check_word("ld_clash", 10'd1, 32'hBEEF_BEEF);
        check_status("ld_clash", 16'd0, 16'd1, 1'b1);

        // ---------------- counter saturation ----------------
        b1.R_req  = 1'b1;
        b1.W_req  = 4'hF;
        b1.W_data = 32'h0;
        b1.addr   = 32'd40;
        repeat (65537) @(negedge clk);
        clear_bus();
        @(negedge clk);
        check_status("sat", 16'hFFFF, 16'hFFFF, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_mem_responder.md
Name: conv_mem_responder

Overview:
- Word-addressed SRAM responder serving the conv engine's memory-port protocol (R_req / addr / R_data / W_req / W_data).
- One instance backs M0 (image, weights, bias) and another backs M1 (results).
- Provides the following on top of the memory array:
  - programmable read latency;
  - byte-lane writes;
  - a bench-side preload/peek port;
  - access counters and a sticky error flag.
- This makes engine-side handshakes checkable cycle by cycle.

Parameters:
DEPTH, 1024, number of 32-bit words (>= 794 required for M0 image+weights+bias)
AW, 10, word-index width, = clog2(DEPTH)
RD_LAT, 1, cycles from sampled R_req to R_data/R_valid (legal range 1..4)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
R_req  in  1  read request, sampled each posedge
addr  in  32  byte address; word index = addr[AW+1:2]
W_req  in  4  byte-lane write enables, bit i writes W_data[8i+7:8i]
W_data  in  32  write data
R_data  out  32  read data, registered
R_valid  out  1  one-cycle pulse marking R_data update
ld_en  in  1  bench preload/peek strobe
ld_we  in  1  1 = preload write, 0 = peek
ld_addr  in  AW  preload/peek word index
ld_wdata  in  32  preload data
ld_rdata  out  32  peek data, combinational from array
rd_cnt  out  16  count of accepted reads
wr_cnt  out  16  count of accepted writes (W_req != 0)
err  out  1  sticky error flag

Behaviour:
- Reset (rst==0 at posedge):
  - R_data=0, R_valid=0, rd_cnt=0, wr_cnt=0, err=0.
  - Read pipeline stages are flushed to invalid.
  - Array contents are NOT cleared; preload survives reset.
- Reset mid-operation: in-flight reads are discarded, and no R_valid pulse is issued for them after reset.
- Read:
  - R_req=1 at posedge N captures the word at addr into pipe stage 0.
  - R_data is updated and R_valid=1 at posedge N+RD_LAT-1+1; e.g. RD_LAT=1 gives the value visible in cycle N+1.
  - R_data holds its value between reads.
  - Reads are fully pipelined: back-to-back R_req every cycle each yield one result, in order.
- Write: W_req!=0 at posedge writes the enabled bytes only. Other bytes are unchanged.
- Read/write collision (same word, same cycle) is read-first: the read returns the pre-write word.
- Address checks:
  - addr[1:0]!=0 with R_req or W_req!=0 sets err. The access still proceeds using the truncated word index.
  - Word index >= DEPTH (any of addr[31:AW+2] set, or index beyond DEPTH) sets err:
    - the write is suppressed;
    - the read returns 32'h0 (R_valid still pulses).
- Preload port:
  - ld_en & ld_we writes ld_wdata to ld_addr as a full word.
  - If the bus port writes the same word in the same cycle, the preload wins, the bus write is dropped, and err is set.
  - A preload to a different word proceeds in parallel with the bus access.
  - ld_rdata is always the array value at ld_addr (asynchronous peek, for result dump).
- Counters:
  - rd_cnt increments per R_req; wr_cnt increments per W_req!=0.
  - Preload accesses are not counted.
  - Both counters saturate at 16'hFFFF; no wrap-around.
- err is sticky until reset.
- R_req and W_req may be asserted together: both are serviced, per the collision rule above.

Test Plan:
- Preload word 783 = 32'h0001_8000 via ld port; RD_LAT=1; R_req=1, addr=783<<2 at cycle 10 -> R_data=32'h0001_8000, R_valid=1 in cycle 11 only; rd_cnt=1.
- RD_LAT=3; R_req held for 4 cycles, addr 0,4,8,12, words preloaded 10,11,12,13 -> R_valid high for 4 consecutive cycles starting 3 cycles after the first request, R_data 10,11,12,13 in order.
- Word 5 = 32'hAABBCCDD; W_req=4'b0101, W_data=32'h11223344, addr=20 -> peek word 5 = 32'hAA22CC44; wr_cnt=1; err=0.
- Same cycle: R_req=1 and W_req=4'hF on addr=20, W_data=32'h0 with old word 32'h5 -> R_data=32'h5; the next read returns 32'h0.
- addr=32'h0000_1002 read, then addr=DEPTH<<2 write of 32'hFFFF_FFFF -> err=1 after the first access; the out-of-range write is dropped and R_data=0 for the out-of-range read; err stays 1 until rst=0.
- Issue a read, then assert rst=0 for one cycle before R_valid -> no R_valid pulse; R_data=0; counters=0; preloaded array contents unchanged.
